// File: rtl/icache_pkg.sv
// Shared types, response codes and derived-width helpers for the n-way instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_MISS_AR,
        S_MISS_R,
        S_RESP,
        S_FLUSH
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int off_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_width, input int sets, input int line_bytes);
        return addr_width - $clog2(sets) - $clog2(line_bytes);
    endfunction

    // Kept at least 1 so single-beat lines still have a legal beat counter.
    function automatic int word_w(input int line_bytes, input int data_width);
        int beats;
        beats = line_bytes * 8 / data_width;
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// One way of the instruction cache: valid/tag per set with combinational lookup,
// beat-granular data storage with a registered read port, and single-cycle bulk invalidate.
module icache_way_array
    import icache_pkg::*;
#(
    parameter int TAG_W      = 22,
    parameter int IDX_W      = 6,
    parameter int WORD_W     = 1,
    parameter int SETS       = 64,
    parameter int BEATS      = 2,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      lk_idx,
    output logic                  lk_valid,
    output logic [TAG_W-1:0]      lk_tag,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic [WORD_W-1:0]     rd_word,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic                  beat_we,
    input  logic [WORD_W-1:0]     beat_word,
    input  logic [DATA_WIDTH-1:0] beat_data,
    input  logic                  tag_we,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  wr_valid,
    input  logic                  inval,
    input  logic                  clr_all
);

    logic [SETS-1:0]       valid;
    logic [TAG_W-1:0]      tags [SETS];
    logic [DATA_WIDTH-1:0] data [SETS][BEATS];

    assign lk_valid = valid[lk_idx];
    assign lk_tag   = tags[lk_idx];

    always_ff @(posedge clk) begin
        if (rst || clr_all) begin
            valid <= '0;
        end else begin
            if (inval)  valid[wr_idx] <= 1'b0;
            if (tag_we) valid[wr_idx] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we)  tags[wr_idx] <= wr_tag;
        if (beat_we) data[wr_idx][beat_word] <= beat_data;
        if (rd_en)   rd_data <= data[rd_idx][rd_word];
    end

endmodule

// File: rtl/icache_nway.sv
// Parametrised read-only n-way instruction cache with burst refill, round-robin replacement
// and fence.i flush. Define ICACHE_PERF_EN to add saturating hit/miss counters.
module icache_nway
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    input  logic                  fence_i,
    output logic                  mem_ar_valid_o,
    input  logic                  mem_ar_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_ar_addr_o,
    output logic [7:0]            mem_ar_len_o,
    input  logic                  mem_r_valid_i,
    output logic                  mem_r_ready_o,
    input  logic [DATA_WIDTH-1:0] mem_r_data_i,
    input  logic [1:0]            mem_r_resp_i,
    input  logic                  mem_r_last_i
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]           perf_hit_o,
    output logic [31:0]           perf_miss_o
`endif
);

    localparam int BEATS  = LINE_BYTES * 8 / DATA_WIDTH;
    localparam int OFF_W  = off_w(LINE_BYTES);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_WIDTH, SETS, LINE_BYTES);
    localparam int WORD_W = word_w(LINE_BYTES, DATA_WIDTH);
    localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic [WAY_W-1:0]             way_q;
    logic                         use_rr_q, err_q, fence_pend;
    logic [WORD_W-1:0]            beat_cnt;
    logic [DATA_WIDTH-1:0]        resp_data_q;
    logic [SETS-1:0][WAY_W-1:0]   rr_ptr;

    logic [WAYS-1:0]                  lk_valid;
    logic [WAYS-1:0][TAG_W-1:0]       lk_tag;
    logic [WAYS-1:0][DATA_WIDTH-1:0]  rd_data;

    logic [IDX_W-1:0]  in_idx, q_idx;
    logic [TAG_W-1:0]  in_tag;
    logic [WORD_W-1:0] in_word, q_word;
    logic              hit, vic_rr, fence_req, accept, beat_we, tag_we, err_nx;
    logic [WAY_W-1:0]  hit_way, vic_way;

    assign in_idx  = ar_addr_i[OFF_W +: IDX_W];
    assign in_tag  = ar_addr_i[ADDR_WIDTH-1 -: TAG_W];
    assign in_word = WORD_W'((ar_addr_i >> BYTE_W) & ADDR_WIDTH'(BEATS - 1));
    assign q_idx   = addr_q[OFF_W +: IDX_W];
    assign q_word  = WORD_W'((addr_q >> BYTE_W) & ADDR_WIDTH'(BEATS - 1));

    assign fence_req = fence_pend | fence_i;
    assign accept    = ar_valid_i && ar_ready_o;
    assign beat_we   = (state == S_MISS_R) && mem_r_valid_i;
    assign tag_we    = beat_we && mem_r_last_i;
    assign err_nx    = err_q | (mem_r_resp_i != RESP_OKAY);

    // Downward scan so the lowest-index hit / invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vic_way = rr_ptr[in_idx];
        vic_rr  = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lk_valid[w] && lk_tag[w] == in_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!lk_valid[w]) begin
                vic_way = WAY_W'(w);
                vic_rr  = 1'b0;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way_array #(
            .TAG_W(TAG_W), .IDX_W(IDX_W), .WORD_W(WORD_W),
            .SETS(SETS), .BEATS(BEATS), .DATA_WIDTH(DATA_WIDTH)
        ) u_way (
            .clk       (clk),
            .rst       (rst),
            .lk_idx    (in_idx),
            .lk_valid  (lk_valid[w]),
            .lk_tag    (lk_tag[w]),
            .rd_en     (accept),
            .rd_idx    (in_idx),
            .rd_word   (in_word),
            .rd_data   (rd_data[w]),
            .wr_idx    (q_idx),
            .beat_we   (beat_we && way_q == WAY_W'(w)),
            .beat_word (beat_cnt),
            .beat_data (mem_r_data_i),
            .tag_we    (tag_we && way_q == WAY_W'(w)),
            .wr_tag    (addr_q[ADDR_WIDTH-1 -: TAG_W]),
            .wr_valid  (!err_nx),
            .inval     (state == S_MISS_AR && way_q == WAY_W'(w)),
            .clr_all   (state == S_FLUSH)
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (fence_req)              state_nx = S_FLUSH;
                       else if (ar_valid_i)        state_nx = hit ? S_HIT : S_MISS_AR;
            S_HIT,
            S_RESP:    if (r_ready_i)              state_nx = fence_req ? S_FLUSH : S_IDLE;
            S_MISS_AR: if (mem_ar_ready_i)         state_nx = S_MISS_R;
            S_MISS_R:  if (tag_we)                 state_nx = S_RESP;
            S_FLUSH:                               state_nx = S_IDLE;
            default:                               state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            way_q       <= '0;
            use_rr_q    <= 1'b0;
            err_q       <= 1'b0;
            fence_pend  <= 1'b0;
            beat_cnt    <= '0;
            resp_data_q <= '0;
            rr_ptr      <= '0;
        end else begin
            if (state_nx == S_FLUSH) fence_pend <= 1'b0;
            else if (fence_i)        fence_pend <= 1'b1;
            if (accept) begin
                addr_q   <= ar_addr_i;
                way_q    <= hit ? hit_way : vic_way;
                use_rr_q <= !hit && vic_rr;
            end
            if (beat_we) begin
                beat_cnt <= mem_r_last_i ? '0 : beat_cnt + 1'b1;
                err_q    <= err_nx;
                if (beat_cnt == q_word) resp_data_q <= mem_r_data_i;
                if (mem_r_last_i) begin
                    if (err_nx) resp_data_q <= '0;
                    if (use_rr_q) rr_ptr[q_idx] <= (WAYS == 1) ? '0 : WAY_W'(rr_ptr[q_idx] + 1'b1);
                end
            end
            if (state == S_RESP && r_ready_i) err_q <= 1'b0;
            if (state == S_FLUSH) rr_ptr <= '0;
        end
    end

    assign ar_ready_o     = (state == S_IDLE) && !fence_req;
    assign r_valid_o      = (state == S_HIT) || (state == S_RESP);
    assign r_data_o       = (state == S_HIT) ? rd_data[way_q] : resp_data_q;
    assign r_resp_o       = (state == S_RESP && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign mem_ar_valid_o = (state == S_MISS_AR);
    assign mem_ar_addr_o  = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_ar_len_o   = 8'(BEATS - 1);
    assign mem_r_ready_o  = (state == S_MISS_R);

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hit_o  <= '0;
            perf_miss_o <= '0;
        end else if (state == S_IDLE) begin
            if (state_nx == S_HIT && perf_hit_o != '1)      perf_hit_o  <= perf_hit_o + 32'd1;
            if (state_nx == S_MISS_AR && perf_miss_o != '1) perf_miss_o <= perf_miss_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_nway.sv
// Bench for icache_nway: bench acts as memory and checks every fetch against a
// set/way reference model (default parameters: 2 ways, 64 sets, 16-byte lines, 64-bit words).
module tb_icache_nway;

    logic        clk, rst;
    logic        ar_valid_i, ar_ready_o, r_valid_o, r_ready_i, fence_i;
    logic [31:0] ar_addr_i, mem_ar_addr_o;
    logic [63:0] r_data_o, mem_r_data_i;
    logic [1:0]  r_resp_o, mem_r_resp_i;
    logic        mem_ar_valid_o, mem_ar_ready_i, mem_r_valid_i, mem_r_ready_o, mem_r_last_i;
    logic [7:0]  mem_ar_len_o;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit_o, perf_miss_o;
`endif

    icache_nway dut (
        .clk(clk), .rst(rst),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_resp_o(r_resp_o),
        .fence_i(fence_i),
        .mem_ar_valid_o(mem_ar_valid_o), .mem_ar_ready_i(mem_ar_ready_i),
        .mem_ar_addr_o(mem_ar_addr_o), .mem_ar_len_o(mem_ar_len_o),
        .mem_r_valid_i(mem_r_valid_i), .mem_r_ready_o(mem_r_ready_o),
        .mem_r_data_i(mem_r_data_i), .mem_r_resp_i(mem_r_resp_i), .mem_r_last_i(mem_r_last_i)
`ifdef ICACHE_PERF_EN
        , .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: per set, per way valid/tag, plus round-robin pointer.
    bit          mv [64][2];
    logic [21:0] mt [64][2];
    int          rr [64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h8000000) return a[3] ? 64'h22 : 64'h11;
        return {a[31:3], 3'b0, ~a[31:3], 3'b0} ^ 64'h5a5a_0f0f_3c3c_9696;
    endfunction

    task automatic model_flush();
        for (int s = 0; s < 64; s++) begin
            mv[s][0] = 0;
            mv[s][1] = 0;
            rr[s]    = 0;
        end
    endtask

    // One fetch: err_beat < 0 means no error beat; fence_mid pulses fence_i during refill.
    task automatic fetch(input logic [31:0] a, input int err_beat, input bit fence_mid, input int bp);
        int s, n, vic;
        bit hit, err, fm;
        logic [21:0] t;
        logic [31:0] line;
        logic [63:0] exp_d;
        s    = int'(a[9:4]);
        t    = a[31:10];
        line = {a[31:4], 4'b0};
        hit  = 0;
        for (int w = 0; w < 2; w++) if (mv[s][w] && mt[s][w] == t) hit = 1;
        err  = 0;
        fm   = fence_mid && !hit;

        ar_addr_i  = a;
        ar_valid_i = 1'b1;
        n = 0;
        while (!ar_ready_o && n < 50) begin tick(); n++; end
        chk("ar_ready", ar_ready_o, 1);
        tick();
        ar_valid_i = 1'b0;
        chk("ar_ready_drop", ar_ready_o, 0);
        chk("miss_ar_valid", mem_ar_valid_o, !hit);

        if (!hit) begin
            chk("mem_ar_addr", mem_ar_addr_o, line);
            chk("mem_ar_len", mem_ar_len_o, 1);
            repeat ($urandom_range(0, 2)) tick();
            chk("mem_ar_hold", mem_ar_valid_o, 1);
            mem_ar_ready_i = 1'b1;
            tick();
            mem_ar_ready_i = 1'b0;
            chk("mem_ar_done", mem_ar_valid_o, 0);
            chk("mem_r_ready", mem_r_ready_o, 1);
            for (int b = 0; b < 2; b++) begin
                repeat ($urandom_range(0, 1)) tick();
                mem_r_valid_i = 1'b1;
                mem_r_data_i  = mem_word(line + 32'(b * 8));
                mem_r_resp_i  = (b == err_beat) ? 2'b10 : 2'b00;
                mem_r_last_i  = (b == 1);
                fence_i       = fm && (b == 0);
                if (b == err_beat) err = 1;
                tick();
                mem_r_valid_i = 1'b0;
                mem_r_last_i  = 1'b0;
                mem_r_resp_i  = 2'b00;
                fence_i       = 1'b0;
            end
            chk("mem_r_ready_drop", mem_r_ready_o, 0);
            vic = -1;
            for (int w = 0; w < 2; w++) if (!mv[s][w] && vic < 0) vic = w;
            if (vic < 0) begin
                vic   = rr[s];
                rr[s] = (rr[s] + 1) % 2;
            end
            mv[s][vic] = !err;
            mt[s][vic] = t;
        end

        exp_d = err ? 64'h0 : mem_word(a);
        chk("r_valid", r_valid_o, 1);
        chk("r_resp", r_resp_o, err ? 2'b10 : 2'b00);
        chk("r_data", r_data_o, exp_d);
        repeat (bp) begin
            tick();
            chk("bp_r_valid", r_valid_o, 1);
            chk("bp_r_data", r_data_o, exp_d);
            chk("bp_ar_ready", ar_ready_o, 0);
        end
        r_ready_i = 1'b1;
        tick();
        r_ready_i = 1'b0;
        chk("r_valid_drop", r_valid_o, 0);
        if (fm) begin
            chk("flush_ar_ready", ar_ready_o, 0);
            tick();
            model_flush();
        end
        chk("idle_ar_ready", ar_ready_o, 1);
    endtask

    initial begin
        rst = 1'b1;
        ar_valid_i = 0; ar_addr_i = '0; r_ready_i = 0; fence_i = 0;
        mem_ar_ready_i = 0; mem_r_valid_i = 0; mem_r_data_i = '0; mem_r_resp_i = '0; mem_r_last_i = 0;
        model_flush();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ar_ready", ar_ready_o, 1);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_r_data", r_data_o, 0);
        chk("rst_r_resp", r_resp_o, 0);
        chk("rst_mem_ar_valid", mem_ar_valid_o, 0);
        chk("rst_mem_ar_addr", mem_ar_addr_o, 0);
        chk("rst_mem_r_ready", mem_r_ready_o, 0);

        // Cold miss, hit after fill, same-set replacement.
        fetch(32'h8000_0008, -1, 0, 0);
        fetch(32'h8000_0000, -1, 0, 0);
        fetch(32'h8000_0400, -1, 0, 0);
        fetch(32'h8000_0800, -1, 0, 0);
        fetch(32'h8000_0400, -1, 0, 0);
        fetch(32'h8000_0000, -1, 0, 0);
        // Refill error, then the same line misses again.
        fetch(32'h8000_1008, 0, 0, 0);
        fetch(32'h8000_1008, -1, 0, 0);
        // fence_i during refill, then that line misses; backpressure on a hit.
        fetch(32'h8000_2000, -1, 1, 0);
        fetch(32'h8000_2000, -1, 0, 0);
        fetch(32'h8000_2008, -1, 0, 5);

        // fence_i with a request in IDLE: flush first, request refused that cycle.
        ar_addr_i  = 32'h8000_2000;
        ar_valid_i = 1'b1;
        fence_i    = 1'b1;
        #1;
        chk("fence_req_ar_ready", ar_ready_o, 0);
        tick();
        fence_i    = 1'b0;
        ar_valid_i = 1'b0;
        chk("fence_flush_ar_ready", ar_ready_o, 0);
        tick();
        chk("fence_post_ar_ready", ar_ready_o, 1);
        model_flush();
        fetch(32'h8000_2000, -1, 0, 0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            int eb;
            a  = 32'h8001_0000 | (32'($urandom_range(0, 3)) << 10)
               | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
            eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
            fetch(a, eb, $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
